// File: rtl/booth_r4_mul_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier.
package booth_r4_mul_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int ACC_W     = WIDTH_DEF + 2;

    // Booth digits retired per product: signed-only build, and extended-operand build.
    localparam int DIGITS_SIGNED = WIDTH_DEF / 2;
    localparam int DIGITS_EXT    = (WIDTH_DEF + 2) / 2;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } digit_t;

    // Recode {q[1:0], q_m1} into a signed Booth digit.
    function automatic digit_t booth_digit(input logic [2:0] bits);
        digit_t d;
        case (bits)
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Combinational Booth encoder: one recoded digit selects a partial product.
// Negative digits return the one's complement and raise neg; the adder
// supplies the +1 through its carry-in.
module booth_r4_enc
    import booth_r4_mul_pkg::*;
#(
    parameter int W = ACC_W
)
(
    input  logic [2:0]   bits,
    input  logic [W-1:0] m,
    output logic [W-1:0] pp,
    output logic         neg
);

    digit_t digit;
    logic [W-1:0] m2;

    assign digit = booth_digit(bits);
    assign m2    = {m[W-2:0], 1'b0};

    // Select 0, M, 2M or their complements.
    always_comb begin
        pp  = '0;
        neg = 1'b0;
        case (digit)
            POS1: pp = m;
            POS2: pp = m2;
            NEG1: begin
                pp  = ~m;
                neg = 1'b1;
            end
            NEG2: begin
                pp  = ~m2;
                neg = 1'b1;
            end
            default: begin
                pp  = '0;
                neg = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/booth_r4_mul.sv
// Sequential radix-4 Booth multiplier, one digit per clock, product on hi/lo.
// Optional build macro BOOTH_MUL_UNSIGNED_EN adds the signed_op port and
// extends both operands to WIDTH+2 bits so unsigned products work too.
module booth_r4_mul
    import booth_r4_mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
`ifdef BOOTH_MUL_UNSIGNED_EN
    input  logic             signed_op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int AW = WIDTH + 2;
`ifdef BOOTH_MUL_UNSIGNED_EN
    localparam int QW     = WIDTH + 2;
    localparam int DIGITS = (WIDTH + 2) / 2;
`else
    localparam int QW     = WIDTH;
    localparam int DIGITS = WIDTH / 2;
`endif
    localparam int CW = 6;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    state_t state, state_nx;

    logic [AW-1:0] a, m, pp, sum, a_nx, m_ld;
    logic [QW-1:0] q, q_nx, q_ld;
    logic          qm1, qm1_nx, neg;
    logic [CW-1:0] cnt;
    logic          armed;
    logic          accept, last;
    logic [WIDTH-1:0] hi_nx, lo_nx;
    logic          ext_m;

`ifdef BOOTH_MUL_UNSIGNED_EN
    logic ext_q;
    assign ext_m = signed_op & multiplicand[WIDTH-1];
    assign ext_q = signed_op & multiplier[WIDTH-1];
    assign q_ld  = {{2{ext_q}}, multiplier};
`else
    assign ext_m = multiplicand[WIDTH-1];
    assign q_ld  = multiplier;
`endif
    assign m_ld = {{2{ext_m}}, multiplicand};

    // armed blocks a start that coincides with the first edge after reset release.
    assign accept = (state == IDLE) && start && armed;
    assign last   = (cnt == LAST);

    booth_r4_enc #(.W(AW)) u_enc (
        .bits (q[1:0] == 2'b00 && !qm1 ? 3'b000 : {q[1:0], qm1}),
        .m    (m),
        .pp   (pp),
        .neg  (neg)
    );

    // Three-operand add then 2-bit arithmetic shift of {A, Q, q_m1}.
    always_comb begin
        sum    = a + pp + AW'(neg);
        a_nx   = {{2{sum[AW-1]}}, sum[AW-1:2]};
        q_nx   = {sum[1:0], q[QW-1:2]};
        qm1_nx = q[1];
`ifdef BOOTH_MUL_UNSIGNED_EN
        lo_nx  = q_nx[WIDTH-1:0];
        hi_nx  = {a_nx[WIDTH-3:0], q_nx[WIDTH+1:WIDTH]};
`else
        lo_nx  = q_nx;
        hi_nx  = a_nx[WIDTH-1:0];
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, digit iteration and result latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a     <= '0;
            q     <= '0;
            qm1   <= 1'b0;
            m     <= '0;
            cnt   <= '0;
            armed <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            armed <= 1'b1;
            if (accept) begin
                a   <= '0;
                q   <= q_ld;
                qm1 <= 1'b0;
                m   <= m_ld;
                cnt <= '0;
            end else if (state == CALC) begin
                a   <= a_nx;
                q   <= q_nx;
                qm1 <= qm1_nx;
                cnt <= cnt + 1'b1;
                if (last) begin
                    hi <= hi_nx;
                    lo <= lo_nx;
                end
            end
        end
    end

endmodule

// File: doc/booth_r4_mul.md
# booth_r4_mul

Sequential radix-4 Booth multiplier for the datapath's MUL instruction. Takes two 32-bit operands and produces the 64-bit product as HI/LO words. It retires one Booth digit per clock. Each step sums the accumulator and the selected partial product (with its negation carry-in) as three operands into a 34-bit adder slice. HI/LO feed the register-file HI/LO write port.

## Interface
Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- multiplicand  in  WIDTH  M, captured on accepted start.
- multiplier  in  WIDTH  Q, captured on accepted start.
- signed_op  in  1  present only with BOOTH_MUL_UNSIGNED_EN; 1 = signed, 0 = unsigned; captured with operands.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  single-cycle pulse when hi/lo are valid.
- hi  out  WIDTH  product bits [63:32].
- lo  out  WIDTH  product bits [31:0].

## Operation
- States: IDLE, CALC, DONE.
  - IDLE: on start=1, load A=0 (34 b), Q, q_m1=0, M sign-extended to 34 b, and cnt=0. Go to CALC.
  - CALC: one Booth digit per cycle. Increment cnt. After the last digit, go to DONE.
  - DONE: latch hi/lo, pulse done, return to IDLE.
- Booth digit from {Q[1:0], q_m1}:
  - 000/111 → 0.
  - 001/010 → +M.
  - 011 → +2M.
  - 100 → −2M.
  - 101/110 → −M.
- Negation is performed as ~pp plus a carry-in of 1. A, pp and that carry-in are summed as three operands, mod 2^34.
- After each add, arithmetic-shift {A, Q, q_m1} right by 2. A's sign bit is replicated.
- Digit count is 16 without the macro.
- Result is exactly the low 64 bits of the true product. Signed ⇒ two's-complement result.
- start in CALC or DONE is ignored; no queueing.
- hi/lo hold their last result until the next DONE.
- Operand inputs need only be stable in the start cycle.

## Timing
- Reset values: busy=0, done=0, hi=0, lo=0, state=IDLE, internal registers 0.
- Start accepted at edge 0. busy=1 after edge 0 through the CALC cycles. done=1 and hi/lo valid for one cycle after the final CALC edge.
- Latency from start edge to done-high cycle: 17 cycles (16 CALC + DONE). With the macro it is 18 cycles.
- Throughput: the next start is accepted in the cycle after done.
- rst_n low at any time, including mid-CALC, immediately forces reset values; the partial result is discarded.
- start asserted in the same cycle as rst_n deassertion is ignored; the first accepted start is at the following edge.

## Configuration
- BOOTH_MUL_UNSIGNED_EN:
  - Defined: signed_op port exists. Operands are extended to 34 b: sign-extended if signed_op=1, zero-extended if 0. Q is held as 34 b. Always 17 digits (uniform latency 18) in both modes.
  - Undefined: no signed_op port. Signed-only, 16 digits, latency 17.

## Structure
- Shared package holds:
  - WIDTH default.
  - ACC_W = WIDTH+2.
  - State enum {IDLE, CALC, DONE}.
  - Booth digit encoding type (ZERO, POS1, POS2, NEG1, NEG2).
  - Digit-count constants for both configurations.
- One sub-module: booth_r4_enc. It is combinational and maps {Q[1:0], q_m1} and M to a 34-bit pp plus a neg carry-in bit.
- The FSM, shift register and three-operand add live in the top level.

## Test plan
- 7 × −3 (0x00000007, 0xFFFFFFFD) → hi=0xFFFFFFFF, lo=0xFFFFFFEB. done exactly 17 cycles after start; busy high 16 cycles.
- 0x80000000 × 0x80000000 → hi=0x40000000, lo=0x00000000. −1 × −1 → hi=0, lo=1.
- 0x7FFFFFFF × 0x80000000 → hi=0xC0000000, lo=0x80000000. 0 × 0xDEADBEEF → 0/0.
- start re-pulsed at CALC cycle 5 with different operands → ignored, and the first result is unchanged. The next start one cycle after done is accepted.
- rst_n pulsed low at CALC cycle 8 → busy, done, hi and lo are 0 immediately. A fresh 3 × 5 afterwards gives lo=15, hi=0.
- With BOOTH_MUL_UNSIGNED_EN, 0xFFFFFFFF × 0xFFFFFFFF:
  - signed_op=0 → hi=0xFFFFFFFE, lo=0x00000001, latency 18.
  - signed_op=1 → hi=0, lo=1.
